branch_history_table: RTL and testbench

//  Parametrised table of saturating direction counters for the IF stage. Indexed by PC bits,

---
 rtl/branch_history_table.sv | 103 ++++++++++
 tb/tb_branch_history_table.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Per-PC table of saturating direction counters with an optional gshare history hash.
// Asynchronous-read predictor; trains from resolved branches and self-clears after reset.
module branch_history_table #(
  parameter int ENTRIES  = 64,
  parameter int IDX_W    = 6,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int GHR_W    = 0,
  parameter int PC_LSB   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      lookup_pc,
  output logic             predict_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken,
  output logic             ready
);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  localparam logic [CTR_W-1:0] CMAX   = '1;
  localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT_CTR);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(ENTRIES - 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] hist;
  logic [CTR_W-1:0] table_q [ENTRIES];
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_nx;
  logic             sweep_we;
  logic             upd_we;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sweep_we = 1'b0;
    upd_we   = 1'b0;
    ready    = 1'b0;
    unique case (state)
      S_INIT: begin
        sweep_we = 1'b1;
        if (ptr == LAST) state_nx = S_READY;
      end
      S_READY: begin
        ready  = 1'b1;
        upd_we = update_valid;
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           ptr <= '0;
    else if (sweep_we) ptr <= ptr + 1'b1;
  end

  // History only moves on resolved branches, never on fetch.
  if (GHR_W > 0) begin : g_hist
    logic [GHR_W-1:0] ghr;
    always_ff @(posedge clk) begin
      if (rst)         ghr <= '0;
      else if (upd_we) ghr <= GHR_W'({ghr, update_taken});
    end
    assign hist = IDX_W'(ghr);
  end else begin : g_nohist
    assign hist = '0;
  end

  assign pred_idx      = lookup_pc[PC_LSB +: IDX_W] ^ hist;
  assign predict_taken = ready & table_q[pred_idx][CTR_W-1];

  assign ctr_cur = table_q[update_idx];

  always_comb begin
    ctr_nx = ctr_cur;
    if (update_taken) begin
      if (ctr_cur != CMAX) ctr_nx = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0)   ctr_nx = ctr_cur - 1'b1;
    end
  end

  // Contents are cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we)    table_q[ptr]        <= INIT_V;
      else if (upd_we) table_q[update_idx] <= ctr_nx;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: bimodal and gshare instances
// driven in parallel and checked against an array-based reference model.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        uv = 1'b0;
  logic [5:0]  ui_b = '0;
  logic [5:0]  ui_g = '0;
  logic        ut = 1'b0;
  logic        pt_b, pt_g, rdy_b, rdy_g;
  logic [5:0]  pi_b, pi_g;

  always #5 clk = ~clk;

  branch_history_table #(.GHR_W(0)) u_bim (
    .clk(clk), .rst(rst), .lookup_pc(pc),
    .predict_taken(pt_b), .pred_idx(pi_b),
    .update_valid(uv), .update_idx(ui_b),
    .update_taken(ut), .ready(rdy_b)
  );

  branch_history_table #(.GHR_W(4)) u_gsh (
    .clk(clk), .rst(rst), .lookup_pc(pc),
    .predict_taken(pt_g), .pred_idx(pi_g),
    .update_valid(uv), .update_idx(ui_g),
    .update_taken(ut), .ready(rdy_g)
  );

  typedef struct {
    bit    rdy;
    bit    pb;
    int    ib;
    bit    pg;
    int    ig;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drv_done = 0;

  int ctr_b [64];
  int ctr_g [64];
  int ghr     = 0;
  bit m_ready = 0;
  int m_cnt   = 0;

  function automatic int sat(int c, bit t);
    if (t) return (c < 3) ? c + 1 : c;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic int bidx(logic [31:0] p);
    return int'((p >> 2) % 64);
  endfunction

  task automatic step(input logic [31:0] p, input bit v,
                      input int ib, input int ig,
                      input bit t, input bit r, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    pc   = p;
    uv   = v;
    ui_b = 6'(ib);
    ui_g = 6'(ig);
    ut   = t;
    rst  = r;
    e.rdy = m_ready;
    e.ib  = bidx(p);
    e.ig  = bidx(p) ^ ghr;
    e.pb  = m_ready && (ctr_b[e.ib] >= 2);
    e.pg  = m_ready && (ctr_g[e.ig] >= 2);
    e.tag = tag;
    q.push_back(e);
    if (r) begin
      m_ready = 0;
      m_cnt   = 0;
      ghr     = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 64) begin
        m_ready = 1;
        for (int i = 0; i < 64; i++) begin
          ctr_b[i] = 1;
          ctr_g[i] = 1;
        end
      end
    end else if (v) begin
      ctr_b[ib] = sat(ctr_b[ib], t);
      ctr_g[ig] = sat(ctr_g[ig], t);
      ghr = ((ghr << 1) | int'(t)) % 16;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, " ready_b"}, int'(rdy_b), int'(e.rdy));
        chk({e.tag, " ready_g"}, int'(rdy_g), int'(e.rdy));
        chk({e.tag, " idx_b"},   int'(pi_b),  e.ib);
        chk({e.tag, " idx_g"},   int'(pi_g),  e.ig);
        chk({e.tag, " pred_b"},  int'(pt_b),  int'(e.pb));
        chk({e.tag, " pred_g"},  int'(pt_g),  int'(e.pg));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ig;
    step(0, 0, 0, 0, 0, 1, "reset");
    step(0, 0, 0, 0, 0, 1, "reset");
    for (int i = 0; i < 70; i++)
      step(32'(i) << 2, i < 60, 7, 7, 1, 0, "sweep");
    for (int i = 0; i < 64; i++)
      step(32'(i) << 2, 0, 0, 0, 0, 0, "init_all");
    for (int i = 0; i < 4; i++)
      step(32'h14, 1, 5, 5, 1, 0, "sat_up");
    for (int i = 0; i < 2; i++)
      step(32'h14, 1, 5, 5, 0, 0, "sat_dn");
    step(32'h14, 0, 0, 0, 0, 0, "sat_dn");
    for (int i = 0; i < 2; i++)
      step(32'h24, 1, 9, 9, 0, 0, "sat_low");
    step(32'h24, 0, 0, 0, 0, 0, "sat_low");
    step(32'h100, 1, 0, 0, 1, 0, "alias");
    step(32'h200, 1, 0, 0, 1, 0, "alias");
    step(32'h200, 0, 0, 0, 0, 0, "alias");
    step(0, 0, 0, 0, 0, 1, "rerst");
    for (int i = 0; i < 30; i++)
      step(32'(i) << 2, 0, 0, 0, 0, 0, "sweep2");
    step(0, 0, 0, 0, 0, 1, "rerst");
    for (int i = 0; i < 66; i++)
      step(32'(i) << 2, 0, 0, 0, 0, 0, "sweep3");
    step(0, 1, 3, 3, 1, 0, "gshare");
    step(0, 1, 3, 3, 1, 0, "gshare");
    step(0, 1, 3, 3, 0, 0, "gshare");
    step(0, 1, 3, 3, 1, 0, "gshare");
    step(32'h0,  0, 0, 0, 0, 0, "gshare");
    step(32'h34, 0, 0, 0, 0, 0, "gshare");
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p  = $urandom;
      ig = bidx(p) ^ ghr;
      step(p, ($urandom % 2) == 1, int'($urandom_range(0, 63)),
           (($urandom % 4) != 0) ? ig : int'($urandom_range(0, 63)),
           ($urandom % 3) != 0, ($urandom % 400) == 0, "random");
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
